// File: rtl/redmule_mx_pkg.sv
// Shared types and sizing helpers for the RedMulE MX decoder arbiter.
package redmule_mx_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } mx_arb_state_e;

  // Requester identity: X uses a scalar exponent, W uses per-group exponents.
  typedef enum logic {
    REQ_X = 1'b0,
    REQ_W = 1'b1
  } mx_req_e;

  // Number of FP16 output beats produced per MX value block.
  function automatic int unsigned mx_num_groups(input int unsigned data_w,
                                                input int unsigned num_lanes);
    return data_w / 8 / num_lanes;
  endfunction

  // Beat counter width; never narrower than one bit.
  function automatic int unsigned mx_cnt_w(input int unsigned num_groups);
    return (num_groups > 1) ? $clog2(num_groups) : 1;
  endfunction

endpackage

// File: rtl/redmule_mx_rr_arb2.sv
// Two-way round-robin picker: bit 0 is X, bit 1 is W. On a tie the
// requester that was not served last wins; a single request always wins.
module redmule_mx_rr_arb2
  import redmule_mx_pkg::*;
(
  input  logic [1:0] i_req,
  input  mx_req_e    i_last,
  output logic [1:0] o_grant
);

  // Pick one requester, alternating on ties based on who was served last.
  always_comb begin
    o_grant = 2'b00;
    if (i_req == 2'b11) begin
      o_grant = (i_last == REQ_X) ? 2'b10 : 2'b01;
    end else begin
      o_grant = i_req;
    end
  end

endmodule

// File: rtl/redmule_mx_arbiter.sv
// Shares one MX decoder between the X stream (scalar exponent) and the
// W stream (per-group exponents). Grants round-robin, issues the granted
// block with the matching exponent mode, then holds the grant until all
// NUM_GROUPS FP16 beats have drained back to the owner.
// Optional feature macro: REDMULE_MX_ARB_PERF_EN enables the 32-bit
// accepted-issue counters on x_grants_o / w_grants_o.
module redmule_mx_arbiter
  import redmule_mx_pkg::*;
#(
  parameter int unsigned DATA_W       = 256,
  parameter int unsigned BITW         = 16,
  parameter int unsigned NUM_LANES    = 1,
  parameter int unsigned MX_EXP_WIDTH = (DATA_W / 8 / NUM_LANES) * 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      x_valid_i,
  output logic                      x_ready_o,
  input  logic [DATA_W-1:0]         x_val_i,
  input  logic [7:0]                x_exp_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [DATA_W-1:0]         w_val_i,
  input  logic [MX_EXP_WIDTH-1:0]   w_exp_i,
  output logic                      dec_val_valid_o,
  output logic                      dec_exp_valid_o,
  input  logic                      dec_val_ready_i,
  input  logic                      dec_exp_ready_i,
  output logic [DATA_W-1:0]         dec_val_o,
  output logic [MX_EXP_WIDTH-1:0]   dec_exp_o,
  output logic                      dec_vector_exp_o,
  input  logic                      dec_fp16_valid_i,
  output logic                      dec_fp16_ready_o,
  input  logic [NUM_LANES*BITW-1:0] dec_fp16_i,
  output logic                      x_fp16_valid_o,
  input  logic                      x_fp16_ready_i,
  output logic [NUM_LANES*BITW-1:0] x_fp16_o,
  output logic                      w_fp16_valid_o,
  input  logic                      w_fp16_ready_i,
  output logic [NUM_LANES*BITW-1:0] w_fp16_o,
  output logic [31:0]               x_grants_o,
  output logic [31:0]               w_grants_o
);

  localparam int unsigned NUM_GROUPS = mx_num_groups(DATA_W, NUM_LANES);
  localparam int unsigned CNT_W      = mx_cnt_w(NUM_GROUPS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_GROUPS - 1);

  mx_arb_state_e    r_state;
  mx_req_e          r_owner;
  mx_req_e          r_last;
  logic [CNT_W-1:0] r_beatCnt;

  mx_arb_state_e    w_stateNext;
  mx_req_e          w_ownerNext;
  mx_req_e          w_lastNext;
  logic [CNT_W-1:0] w_beatCntNext;
  logic [1:0]       w_grant;
  logic             w_issueHs;
  logic             w_beatHs;

  redmule_mx_rr_arb2 u_rr_arb2 (
    .i_req   ({w_valid_i, x_valid_i}),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  // State register; reset leaves last = W so X wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_owner   <= REQ_X;
      r_last    <= REQ_W;
      r_beatCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_owner   <= w_ownerNext;
      r_last    <= w_lastNext;
      r_beatCnt <= w_beatCntNext;
    end
  end

  // Next-state and output muxing; every output is zero outside its active state.
  always_comb begin
    w_stateNext      = r_state;
    w_ownerNext      = r_owner;
    w_lastNext       = r_last;
    w_beatCntNext    = r_beatCnt;
    w_issueHs        = 1'b0;
    w_beatHs         = 1'b0;
    x_ready_o        = 1'b0;
    w_ready_o        = 1'b0;
    dec_val_valid_o  = 1'b0;
    dec_exp_valid_o  = 1'b0;
    dec_val_o        = '0;
    dec_exp_o        = '0;
    dec_vector_exp_o = 1'b0;
    dec_fp16_ready_o = 1'b0;
    x_fp16_valid_o   = 1'b0;
    x_fp16_o         = '0;
    w_fp16_valid_o   = 1'b0;
    w_fp16_o         = '0;

    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_ownerNext = w_grant[1] ? REQ_W : REQ_X;
          w_stateNext = ISSUE;
        end
      end

      ISSUE: begin
        dec_val_valid_o = 1'b1;
        dec_exp_valid_o = 1'b1;
        w_issueHs       = dec_val_ready_i & dec_exp_ready_i;
        if (r_owner == REQ_X) begin
          dec_val_o        = x_val_i;
          dec_exp_o        = MX_EXP_WIDTH'(x_exp_i);
          dec_vector_exp_o = 1'b0;
          x_ready_o        = w_issueHs;
        end else begin
          dec_val_o        = w_val_i;
          dec_exp_o        = w_exp_i;
          dec_vector_exp_o = 1'b1;
          w_ready_o        = w_issueHs;
        end
        if (w_issueHs) begin
          w_stateNext   = DRAIN;
          w_beatCntNext = '0;
        end
      end

      DRAIN: begin
        if (r_owner == REQ_X) begin
          x_fp16_o         = dec_fp16_i;
          x_fp16_valid_o   = dec_fp16_valid_i;
          dec_fp16_ready_o = x_fp16_ready_i;
          w_beatHs         = dec_fp16_valid_i & x_fp16_ready_i;
        end else begin
          w_fp16_o         = dec_fp16_i;
          w_fp16_valid_o   = dec_fp16_valid_i;
          dec_fp16_ready_o = w_fp16_ready_i;
          w_beatHs         = dec_fp16_valid_i & w_fp16_ready_i;
        end
        if (w_beatHs) begin
          if (r_beatCnt == LAST_BEAT) begin
            w_stateNext   = IDLE;
            w_beatCntNext = '0;
            w_lastNext    = r_owner;
          end else begin
            w_beatCntNext = r_beatCnt + 1'b1;
          end
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

`ifdef REDMULE_MX_ARB_PERF_EN
  logic [31:0] r_xGrants;
  logic [31:0] r_wGrants;

  // Count accepted issues per requester; counters wrap naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_xGrants <= '0;
      r_wGrants <= '0;
    end else begin
      if (w_issueHs && (r_owner == REQ_X)) begin
        r_xGrants <= r_xGrants + 32'd1;
      end
      if (w_issueHs && (r_owner == REQ_W)) begin
        r_wGrants <= r_wGrants + 32'd1;
      end
    end
  end

  assign x_grants_o = r_xGrants;
  assign w_grants_o = r_wGrants;
`else
  assign x_grants_o = '0;
  assign w_grants_o = '0;
`endif

endmodule
